// File: rtl/button_debouncer.sv
// button_debouncer: synchronises, qualifies and normalises one button pin.
// out is a clean level (1 = pressed); busy flags an in-progress qualification.
module button_debouncer #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 20,
  parameter int SYNC_STAGES   = 2,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic busy
);

  // Pin level when the button is released.
  localparam logic IDLE = ACTIVE_LOW;

  // Counter value on the last confirming cycle.
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("STABLE_CYCLES must be >= 1");
  end

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end

  if ((64'd1 << CNT_W) <= 64'(STABLE_CYCLES - 1))
  begin : g_bad_cnt
    $error("CNT_W too narrow for STABLE_CYCLES");
  end

  // Encoding chosen so out and busy are plain state bits.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {SYNC_STAGES{IDLE}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
    end
  end

  assign s = sync[SYNC_STAGES-1] ^ IDLE;

  // Hold the qualification state and stability count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: any opposite sample restarts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      STABLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign out  = state_q[1];
  assign busy = state_q[0];

endmodule
